// File: rtl/plc_io_scanner.sv
// plc_io_scanner: scans a bank of digital_io channels one at a time, driving
// snapshotted output/direction values and debouncing sampled pin values into
// a stable input process image.
module plc_io_scanner #(
    parameter int unsigned N_CH    = 8,
    parameter int unsigned SETTLE  = 2,
    parameter int unsigned DEB_CNT = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            scan_req,
    input  logic            auto_en,
    input  logic [N_CH-1:0] dir_cfg,
    input  logic [N_CH-1:0] out_img,
    output logic [N_CH-1:0] in_img,
    output logic            busy,
    output logic            scan_done,
    output logic [15:0]     scan_count,
    output logic [N_CH-1:0] ch_en,
    output logic [N_CH-1:0] ch_dir,
    output logic [N_CH-1:0] ch_data_in,
    input  logic [N_CH-1:0] ch_data_out
);

    localparam int unsigned IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int unsigned SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam int unsigned CNT_W = 4;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LATCH  = 3'd1,
        SELECT = 3'd2,
        NEXT   = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t state_q, state_d;

    logic [IDX_W-1:0] idx_q, idx_d;
    logic [SET_W-1:0] settle_q, settle_d;
    logic [N_CH-1:0]  dir_sh_q, dir_sh_d;
    logic [N_CH-1:0]  out_sh_q, out_sh_d;
    logic [CNT_W-1:0] cnt_q [N_CH];
    logic [CNT_W-1:0] cnt_d [N_CH];

    logic [N_CH-1:0]  in_img_q, in_img_d;
    logic             busy_q, busy_d;
    logic             scan_done_q, scan_done_d;
    logic [15:0]      scan_count_q, scan_count_d;
    logic [N_CH-1:0]  ch_en_q, ch_en_d;
    logic [N_CH-1:0]  ch_dir_q, ch_dir_d;
    logic [N_CH-1:0]  ch_data_in_q, ch_data_in_d;

    logic             last_settle_c;
    logic             last_ch_c;
    logic             sample_c;

    assign last_settle_c = (settle_q == SET_W'(SETTLE - 1));
    assign last_ch_c     = (idx_q == IDX_W'(N_CH - 1));
    assign sample_c      = ch_data_out[idx_q];

    // State register; reset aborts any scan in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: idle -> latch -> (select, next) per channel -> done.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (scan_req || auto_en) state_d = LATCH;
            LATCH:   state_d = SELECT;
            SELECT:  if (last_settle_c) state_d = NEXT;
            NEXT:    state_d = last_ch_c ? DONE : SELECT;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath and output next values; outputs track the state being entered.
    always_comb begin
        idx_d        = idx_q;
        settle_d     = '0;
        dir_sh_d     = dir_sh_q;
        out_sh_d     = out_sh_q;
        cnt_d        = cnt_q;
        in_img_d     = in_img_q;
        scan_count_d = scan_count_q;
        ch_dir_d     = ch_dir_q;
        ch_data_in_d = ch_data_in_q;

        case (state_q)
            LATCH: begin
                dir_sh_d = dir_cfg;
                out_sh_d = out_img;
                idx_d    = '0;
            end
            SELECT: begin
                if (!last_settle_c) begin
                    settle_d = settle_q + SET_W'(1);
                end else if (dir_sh_q[idx_q]) begin
                    // Output channels reflect the driven value back into the image.
                    in_img_d[idx_q] = out_sh_q[idx_q];
                    cnt_d[idx_q]    = '0;
                end else if (sample_c == in_img_q[idx_q]) begin
                    cnt_d[idx_q] = '0;
                end else if ((cnt_q[idx_q] + CNT_W'(1)) == CNT_W'(DEB_CNT)) begin
                    in_img_d[idx_q] = sample_c;
                    cnt_d[idx_q]    = '0;
                end else begin
                    cnt_d[idx_q] = cnt_q[idx_q] + CNT_W'(1);
                end
            end
            NEXT: begin
                if (!last_ch_c) idx_d = idx_q + IDX_W'(1);
            end
            DONE: begin
                scan_count_d = scan_count_q + 16'd1;
            end
            default: ;
        endcase

        // Channel drive bits update only when a channel is first selected.
        if ((state_q != SELECT) && (state_d == SELECT)) begin
            ch_dir_d[idx_d]     = dir_sh_d[idx_d];
            ch_data_in_d[idx_d] = out_sh_d[idx_d];
        end

        ch_en_d     = (state_d == SELECT) ? (N_CH'(1) << idx_d) : '0;
        busy_d      = (state_d != IDLE);
        scan_done_d = (state_d == DONE);
    end

    // Datapath and output registers; all cleared to the safe input state on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q        <= '0;
            settle_q     <= '0;
            dir_sh_q     <= '0;
            out_sh_q     <= '0;
            cnt_q        <= '{default: '0};
            in_img_q     <= '0;
            busy_q       <= 1'b0;
            scan_done_q  <= 1'b0;
            scan_count_q <= '0;
            ch_en_q      <= '0;
            ch_dir_q     <= '0;
            ch_data_in_q <= '0;
        end else begin
            idx_q        <= idx_d;
            settle_q     <= settle_d;
            dir_sh_q     <= dir_sh_d;
            out_sh_q     <= out_sh_d;
            cnt_q        <= cnt_d;
            in_img_q     <= in_img_d;
            busy_q       <= busy_d;
            scan_done_q  <= scan_done_d;
            scan_count_q <= scan_count_d;
            ch_en_q      <= ch_en_d;
            ch_dir_q     <= ch_dir_d;
            ch_data_in_q <= ch_data_in_d;
        end
    end

    assign in_img     = in_img_q;
    assign busy       = busy_q;
    assign scan_done  = scan_done_q;
    assign scan_count = scan_count_q;
    assign ch_en      = ch_en_q;
    assign ch_dir     = ch_dir_q;
    assign ch_data_in = ch_data_in_q;

endmodule

// File: tb/tb_plc_io_scanner.sv
// Directed bench for plc_io_scanner with default parameters (8 ch, settle 2, debounce 3).
module tb_plc_io_scanner;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        scan_req = 1'b0;
    logic        auto_en = 1'b0;
    logic [7:0]  dir_cfg = '0;
    logic [7:0]  out_img = '0;
    logic [7:0]  ch_data_out = '0;
    logic [7:0]  in_img;
    logic        busy;
    logic        scan_done;
    logic [15:0] scan_count;
    logic [7:0]  ch_en;
    logic [7:0]  ch_dir;
    logic [7:0]  ch_data_in;

    int checks = 0;
    int errors = 0;

    plc_io_scanner #(.N_CH(8), .SETTLE(2), .DEB_CNT(3)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .scan_req    (scan_req),
        .auto_en     (auto_en),
        .dir_cfg     (dir_cfg),
        .out_img     (out_img),
        .in_img      (in_img),
        .busy        (busy),
        .scan_done   (scan_done),
        .scan_count  (scan_count),
        .ch_en       (ch_en),
        .ch_dir      (ch_dir),
        .ch_data_in  (ch_data_in),
        .ch_data_out (ch_data_out)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        scan_req = 1'b0;
        auto_en  = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    // Pulse scan_req from idle, wait for scan_done, then step into idle.
    task automatic run_scan(output int n);
        n = 0;
        scan_req = 1'b1;
        tick();
        scan_req = 1'b0;
        n = 1;
        while (!scan_done && n < 60) begin
            tick();
            n++;
        end
        checks++;
        if (scan_done !== 1'b1) begin
            errors++;
            $display("FAIL scan_timeout scan_done=%0b required 1", scan_done);
        end
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 5; i++) begin
            scan_req    = 1'($urandom);
            auto_en     = 1'($urandom);
            dir_cfg     = 8'($urandom);
            out_img     = 8'($urandom);
            ch_data_out = 8'($urandom);
            tick();
            checks++;
            if ({ch_en, ch_dir, ch_data_in, in_img} !== 32'd0 || busy !== 1'b0
                || scan_done !== 1'b0 || scan_count !== 16'd0) begin
                errors++;
                $display("FAIL reset_hold en=%h dir=%h din=%h img=%h busy=%0b done=%0b cnt=%0d required all 0",
                         ch_en, ch_dir, ch_data_in, in_img, busy, scan_done, scan_count);
            end
        end
        scan_req = 1'b0;
        auto_en  = 1'b0;
        rst_n    = 1'b1;
        for (int i = 0; i < 50; i++) begin
            tick();
            checks++;
            if ({ch_en, ch_dir, ch_data_in, in_img} !== 32'd0 || busy !== 1'b0
                || scan_done !== 1'b0 || scan_count !== 16'd0) begin
                errors++;
                $display("FAIL reset_idle cyc=%0d en=%h dir=%h din=%h img=%h busy=%0b cnt=%0d required all 0",
                         i, ch_en, ch_dir, ch_data_in, in_img, busy, scan_count);
            end
        end
    endtask

    task automatic test_single_scan();
        int n;
        do_reset();
        dir_cfg     = 8'h0F;
        out_img     = 8'h05;
        ch_data_out = 8'hA0;
        scan_req    = 1'b1;
        tick();
        scan_req = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL single_busy_rise busy=%0b required 1", busy);
        end
        n = 1;
        while (!scan_done && n < 60) begin
            tick();
            n++;
        end
        checks++;
        if (n != 26 || scan_done !== 1'b1) begin
            errors++;
            $display("FAIL single_latency edges=%0d done=%0b required 26 and 1", n, scan_done);
        end
        tick();
        checks++;
        if (busy !== 1'b0 || scan_done !== 1'b0) begin
            errors++;
            $display("FAIL single_busy_fall busy=%0b done=%0b required 0 0", busy, scan_done);
        end
        checks++;
        if (ch_dir !== 8'h0F || ch_data_in !== 8'h05 || in_img !== 8'h05) begin
            errors++;
            $display("FAIL single_scan1 dir=%h din=%h img=%h required 0f 05 05", ch_dir, ch_data_in, in_img);
        end
        run_scan(n);
        checks++;
        if (in_img !== 8'h05) begin
            errors++;
            $display("FAIL single_scan2 img=%h required 05", in_img);
        end
        run_scan(n);
        checks++;
        if (in_img !== 8'hA5) begin
            errors++;
            $display("FAIL single_scan3 img=%h required a5", in_img);
        end
        checks++;
        if (scan_count !== 16'd3) begin
            errors++;
            $display("FAIL single_count cnt=%0d required 3", scan_count);
        end
    endtask

    task automatic test_glitch();
        int n;
        do_reset();
        dir_cfg     = 8'h0F;
        out_img     = 8'h05;
        ch_data_out = 8'h00;
        run_scan(n);
        ch_data_out = 8'h80;
        for (int s = 0; s < 2; s++) begin
            run_scan(n);
            checks++;
            if (in_img !== 8'h05) begin
                errors++;
                $display("FAIL glitch_high%0d img=%h required 05", s, in_img);
            end
        end
        ch_data_out = 8'h00;
        run_scan(n);
        checks++;
        if (in_img !== 8'h05) begin
            errors++;
            $display("FAIL glitch_drop img=%h required 05", in_img);
        end
        ch_data_out = 8'h80;
        for (int s = 0; s < 2; s++) begin
            run_scan(n);
            checks++;
            if (in_img !== 8'h05) begin
                errors++;
                $display("FAIL glitch_accum%0d img=%h required 05", s, in_img);
            end
        end
        scan_req = 1'b1;
        tick();
        scan_req = 1'b0;
        n = 0;
        while (ch_en !== 8'h80 && n < 60) begin
            tick();
            n++;
        end
        checks++;
        if (ch_en !== 8'h80 || in_img[7] !== 1'b0) begin
            errors++;
            $display("FAIL glitch_pre_sample en=%h img7=%0b required 80 0", ch_en, in_img[7]);
        end
        n = 0;
        while (ch_en !== 8'h00 && n < 10) begin
            tick();
            n++;
        end
        checks++;
        if (ch_en !== 8'h00 || in_img[7] !== 1'b1) begin
            errors++;
            $display("FAIL glitch_sample_edge en=%h img7=%0b required 00 1", ch_en, in_img[7]);
        end
        n = 0;
        while (!scan_done && n < 10) begin
            tick();
            n++;
        end
        tick();
        checks++;
        if (in_img !== 8'h85 || busy !== 1'b0) begin
            errors++;
            $display("FAIL glitch_final img=%h busy=%0b required 85 0", in_img, busy);
        end
    endtask

    task automatic test_sequencing();
        logic [7:0] exp_en;
        int j;
        scan_req = 1'b1;
        for (int k = 1; k <= 26; k++) begin
            tick();
            scan_req = 1'b0;
            exp_en = 8'h00;
            if (k >= 2 && k <= 25) begin
                j = k - 2;
                if ((j % 3) < 2) exp_en = 8'h01 << (j / 3);
            end
            checks++;
            if (ch_en !== exp_en || !$onehot0(ch_en)) begin
                errors++;
                $display("FAIL seq_en cyc=%0d en=%h required %h", k, ch_en, exp_en);
            end
        end
        checks++;
        if (scan_done !== 1'b1) begin
            errors++;
            $display("FAIL seq_done done=%0b required 1", scan_done);
        end
        tick();
    endtask

    task automatic test_snapshot();
        int n;
        logic [15:0] cnt0;
        dir_cfg  = 8'hFF;
        out_img  = 8'h05;
        cnt0     = scan_count;
        scan_req = 1'b1;
        tick();
        scan_req = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        out_img  = 8'hFF;
        scan_req = 1'b1;
        tick();
        scan_req = 1'b0;
        n = 0;
        while (!scan_done && n < 60) begin
            tick();
            n++;
        end
        checks++;
        if (scan_done !== 1'b1 || ch_data_in !== 8'h05 || in_img !== 8'h05) begin
            errors++;
            $display("FAIL snap_hold done=%0b din=%h img=%h required 1 05 05", scan_done, ch_data_in, in_img);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (busy !== 1'b0 || ch_en !== 8'h00) begin
                errors++;
                $display("FAIL snap_no_requeue cyc=%0d busy=%0b en=%h required 0 00", i, busy, ch_en);
            end
        end
        checks++;
        if (scan_count !== cnt0 + 16'd1) begin
            errors++;
            $display("FAIL snap_count cnt=%0d required %0d", scan_count, cnt0 + 16'd1);
        end
        run_scan(n);
        checks++;
        if (ch_data_in !== 8'hFF || in_img !== 8'hFF) begin
            errors++;
            $display("FAIL snap_next din=%h img=%h required ff ff", ch_data_in, in_img);
        end
    endtask

    task automatic test_auto_and_reset();
        int n;
        int idle_cyc;
        auto_en = 1'b1;
        n = 0;
        while (!scan_done && n < 60) begin
            tick();
            n++;
        end
        for (int p = 0; p < 2; p++) begin
            n = 0;
            idle_cyc = 0;
            do begin
                tick();
                n++;
                if (busy === 1'b0) idle_cyc++;
            end while (!scan_done && n < 60);
            checks++;
            if (n != 27 || idle_cyc != 1) begin
                errors++;
                $display("FAIL auto_period p=%0d period=%0d idle=%0d required 27 1", p, n, idle_cyc);
            end
        end
        auto_en = 1'b0;
        n = 0;
        while (busy && n < 60) begin
            tick();
            n++;
        end
        for (int i = 0; i < 3; i++) tick();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL auto_stop busy=%0b required 0", busy);
        end

        force dut.scan_count_q = 16'hFFFF;
        tick();
        release dut.scan_count_q;
        tick();
        run_scan(n);
        checks++;
        if (scan_count !== 16'h0000) begin
            errors++;
            $display("FAIL count_wrap cnt=%h required 0000", scan_count);
        end

        scan_req = 1'b1;
        tick();
        scan_req = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        checks++;
        if (ch_en === 8'h00 || busy !== 1'b1) begin
            errors++;
            $display("FAIL abort_pre en=%h busy=%0b required nonzero 1", ch_en, busy);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({ch_en, ch_dir, ch_data_in, in_img} !== 32'd0 || busy !== 1'b0
            || scan_done !== 1'b0 || scan_count !== 16'd0) begin
            errors++;
            $display("FAIL abort_async en=%h dir=%h din=%h img=%h busy=%0b cnt=%0d required all 0",
                     ch_en, ch_dir, ch_data_in, in_img, busy, scan_count);
        end
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 30; i++) begin
            tick();
            checks++;
            if (scan_done !== 1'b0 || busy !== 1'b0 || scan_count !== 16'd0) begin
                errors++;
                $display("FAIL abort_no_done cyc=%0d done=%0b busy=%0b cnt=%0d required 0 0 0",
                         i, scan_done, busy, scan_count);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_scan();
        test_glitch();
        test_sequencing();
        test_snapshot();
        test_auto_and_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
